// File: rtl/baccarat_match_sequencer.sv
// Purpose: match-level controller that restarts the dealing engine each round and tallies results.
// Latency: per round CLEAR 1 + DEAL n + TALLY 1 + CHECK 1 cycles; counters visible the cycle after TALLY.
// Backpressure: none; start_match/next_round are level inputs honoured only in IDLE/HOLD/DONE/ERROR.
module baccarat_match_sequencer #(
    parameter int ROUNDS         = 5,
    parameter int WIN_TARGET     = 3,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic       start_match,
    input  logic       next_round,
    input  logic       player_win_light,
    input  logic       dealer_win_light,
    output logic       engine_resetb,
    output logic       busy,
    output logic [3:0] round_num,
    output logic [3:0] player_wins,
    output logic [3:0] dealer_wins,
    output logic [3:0] ties,
    output logic       match_over,
    output logic [1:0] match_winner,
    output logic       error
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_DEAL  = 3'd2;
    localparam logic [2:0] S_TALLY = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_HOLD  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ERROR = 3'd7;

    localparam logic [3:0] ROUNDS_4   = 4'(ROUNDS);
    localparam logic [3:0] TARGET_4   = 4'(WIN_TARGET);
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [2:0] state_q,  state_d;
    logic [7:0] timer_q,  timer_d;
    logic [1:0] result_q, result_d;
    logic [3:0] round_q,  round_d;
    logic [3:0] pwins_q,  pwins_d;
    logic [3:0] dwins_q,  dwins_d;
    logic [3:0] ties_q,   ties_d;
    logic [1:0] winner_q, winner_d;

    // Counters stop at 15 rather than wrapping back to zero.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Next-state and counter update logic for the match FSM.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        result_d = result_q;
        round_d  = round_q;
        pwins_d  = pwins_q;
        dwins_d  = dwins_q;
        ties_d   = ties_q;
        winner_d = winner_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                // A new match wipes the previous tally; leaving ERROR clears error.
                if (start_match) begin
                    round_d  = 4'd0;
                    pwins_d  = 4'd0;
                    dwins_d  = 4'd0;
                    ties_d   = 4'd0;
                    winner_d = 2'b00;
                    state_d  = S_CLEAR;
                end
            end
            S_CLEAR: begin
                // Engine sees its reset low for this single cycle.
                timer_d = 8'd0;
                state_d = S_DEAL;
            end
            S_DEAL: begin
                // Lights are only trusted here; stale lights later in the round are ignored.
                if (player_win_light || dealer_win_light) begin
                    result_d = {dealer_win_light, player_win_light};
                    state_d  = S_TALLY;
                end else if (timer_q == TIMER_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_TALLY: begin
                case (result_q)
                    2'b01:   pwins_d = sat_inc(pwins_q);
                    2'b10:   dwins_d = sat_inc(dwins_q);
                    2'b11:   ties_d  = sat_inc(ties_q);
                    default: ;
                endcase
                round_d = sat_inc(round_q);
                state_d = S_CHECK;
            end
            S_CHECK: begin
                // Counters already hold this round's result here.
                if ((pwins_q == TARGET_4) || (dwins_q == TARGET_4) || (round_q == ROUNDS_4)) begin
                    state_d = S_DONE;
                    if (pwins_q > dwins_q)
                        winner_d = 2'b01;
                    else if (dwins_q > pwins_q)
                        winner_d = 2'b10;
                    else
                        winner_d = 2'b11;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                // next_round wins over start_match; start_match alone does nothing here.
                if (next_round)
                    state_d = S_CLEAR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset taking priority over everything.
    always_ff @(posedge slow_clock) begin
        if (!resetb) begin
            state_q  <= S_IDLE;
            timer_q  <= 8'd0;
            result_q <= 2'b00;
            round_q  <= 4'd0;
            pwins_q  <= 4'd0;
            dwins_q  <= 4'd0;
            ties_q   <= 4'd0;
            winner_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            result_q <= result_d;
            round_q  <= round_d;
            pwins_q  <= pwins_d;
            dwins_q  <= dwins_d;
            ties_q   <= ties_d;
            winner_q <= winner_d;
        end
    end

    // Engine stays out of reset after a round so its lights remain visible.
    assign engine_resetb = (state_q == S_DEAL) || (state_q == S_TALLY) || (state_q == S_CHECK) ||
                           (state_q == S_HOLD) || (state_q == S_DONE);
    assign busy          = (state_q == S_CLEAR) || (state_q == S_DEAL) ||
                           (state_q == S_TALLY) || (state_q == S_CHECK);
    assign match_over    = (state_q == S_DONE);
    assign error         = (state_q == S_ERROR);
    assign round_num     = round_q;
    assign player_wins   = pwins_q;
    assign dealer_wins   = dwins_q;
    assign ties          = ties_q;
    assign match_winner  = winner_q;

endmodule

// File: tb/tb_baccarat_match_sequencer.sv
// Purpose: scoreboard bench for baccarat_match_sequencer using directed rounds.
// Latency: expectations queued one cycle ahead; monitor compares on every visible tally/status change.
// Backpressure: none; the bench drives level inputs and never waits on the DUT.
module tb_baccarat_match_sequencer;

    localparam int ROUNDS = 5;
    localparam int WT     = 3;

    logic       slow_clock = 1'b0;
    logic       resetb, start_match, next_round, player_win_light, dealer_win_light;
    logic       engine_resetb, busy, match_over, error;
    logic [3:0] round_num, player_wins, dealer_wins, ties;
    logic [1:0] match_winner;

    always #5 slow_clock = ~slow_clock;

    baccarat_match_sequencer #(.ROUNDS(ROUNDS), .WIN_TARGET(WT), .TIMEOUT_CYCLES(15)) dut (
        .slow_clock       (slow_clock),
        .resetb           (resetb),
        .start_match      (start_match),
        .next_round       (next_round),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light),
        .engine_resetb    (engine_resetb),
        .busy             (busy),
        .round_num        (round_num),
        .player_wins      (player_wins),
        .dealer_wins      (dealer_wins),
        .ties             (ties),
        .match_over       (match_over),
        .match_winner     (match_winner),
        .error            (error)
    );

    typedef struct packed {
        logic [3:0] rn;
        logic [3:0] pw;
        logic [3:0] dw;
        logic [3:0] ti;
        logic       mo;
        logic [1:0] mw;
        logic       err;
        logic       erb;
        logic       bsy;
    } snap_t;

    snap_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    mon_on = 1'b0;
    snap_t prev_s;

    // Expected-value model state.
    logic [3:0] m_rn, m_pw, m_dw, m_ti;
    logic       m_mo, m_err;
    logic [1:0] m_mw;

    function automatic snap_t cur_snap();
        snap_t s;
        s = '{round_num, player_wins, dealer_wins, ties, match_over, match_winner,
              error, engine_resetb, busy};
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: whenever round count, match_over or error changes, pop and compare the full snapshot.
    always @(negedge slow_clock) begin
        snap_t c, e;
        if (mon_on) begin
            c = cur_snap();
            if ({c.rn, c.mo, c.err} != {prev_s.rn, prev_s.mo, prev_s.err}) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected actual=%h required=none", c);
                end else begin
                    e = exp_q.pop_front();
                    if (c !== e) begin
                        errors++;
                        $display("FAIL sb_event actual=%h required=%h", c, e);
                    end
                end
            end
            prev_s = c;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge slow_clock);
        #1;
    endtask

    task automatic push_exp(input logic bsy, input logic erb);
        snap_t s;
        s = '{m_rn, m_pw, m_dw, m_ti, m_mo, m_mw, m_err, erb, bsy};
        exp_q.push_back(s);
    endtask

    task automatic model_clear();
        m_rn = 4'd0; m_pw = 4'd0; m_dw = 4'd0; m_ti = 4'd0;
        m_mo = 1'b0; m_err = 1'b0; m_mw = 2'b00;
    endtask

    // Start a match from IDLE/DONE/ERROR; lands in CLEAR.
    task automatic start_new();
        start_match = 1'b1;
        if (m_rn != 0 || m_mo || m_err) begin
            model_clear();
            push_exp(1'b1, 1'b0);
        end else begin
            model_clear();
        end
        tick();
        start_match = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_erb", engine_resetb, 0);
        chk("start_err", error, 0);
    endtask

    // From CLEAR: deal n cycles, result lands on the n-th DEAL edge; ends in HOLD or DONE.
    task automatic do_round(input logic [1:0] res, input int n, output bit ended);
        chk("clear_erb", engine_resetb, 0);
        {dealer_win_light, player_win_light} = 2'b00;
        tick();
        chk("deal_erb", engine_resetb, 1);
        repeat (n - 1) tick();
        {dealer_win_light, player_win_light} = res;
        case (res)
            2'b01:   m_pw = m_pw + 4'd1;
            2'b10:   m_dw = m_dw + 4'd1;
            default: m_ti = m_ti + 4'd1;
        endcase
        m_rn = m_rn + 4'd1;
        push_exp(1'b1, 1'b1);
        tick();
        tick();
        ended = (m_pw == WT) || (m_dw == WT) || (m_rn == ROUNDS);
        if (ended) begin
            m_mo = 1'b1;
            m_mw = (m_pw > m_dw) ? 2'b01 : (m_dw > m_pw) ? 2'b10 : 2'b11;
            push_exp(1'b0, 1'b1);
        end
        tick();
        chk("post_busy", busy, 0);
        chk("post_erb", engine_resetb, 1);
    endtask

    task automatic advance();
        next_round = 1'b1;
        tick();
        next_round = 1'b0;
    endtask

    initial begin
        bit         ended;
        logic [1:0] mix_res [5];
        int         mix_n   [5];
        mix_res = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b01};
        mix_n   = '{3, 2, 1, 4, 2};

        resetb = 1'b0; start_match = 1'b0; next_round = 1'b0;
        player_win_light = 1'b0; dealer_win_light = 1'b0;
        repeat (2) tick();
        chk("rst_round", round_num, 0);
        chk("rst_pw", player_wins, 0);
        chk("rst_dw", dealer_wins, 0);
        chk("rst_ties", ties, 0);
        chk("rst_over", match_over, 0);
        chk("rst_winner", match_winner, 0);
        chk("rst_err", error, 0);
        chk("rst_busy", busy, 0);
        chk("rst_erb", engine_resetb, 0);
        resetb = 1'b1;
        tick();
        chk("idle_busy", busy, 0);
        model_clear();
        prev_s = cur_snap();
        mon_on = 1'b1;

        // Player sweep: wins on the 3rd DEAL cycle, match ends at WIN_TARGET.
        start_new();
        for (int r = 0; r < 3; r++) begin
            do_round(2'b01, 3, ended);
            if (!ended) advance();
        end
        chk("sweep_over", match_over, 1);
        chk("sweep_pw", player_wins, 3);
        chk("sweep_round", round_num, 3);
        chk("sweep_winner", match_winner, 2'b01);
        chk("sweep_erb", engine_resetb, 1);
        next_round = 1'b1;
        tick();
        next_round = 1'b0;
        chk("done_ignores_next", match_over, 1);

        // All ties on the first DEAL cycle.
        start_new();
        for (int r = 0; r < 5; r++) begin
            do_round(2'b11, 1, ended);
            if (!ended) advance();
        end
        chk("ties_ties", ties, 5);
        chk("ties_round", round_num, 5);
        chk("ties_over", match_over, 1);
        chk("ties_winner", match_winner, 2'b11);

        // Mixed match P, D, T, D, P.
        start_new();
        for (int r = 0; r < 5; r++) begin
            do_round(mix_res[r], mix_n[r], ended);
            if (!ended) advance();
        end
        chk("mix_pw", player_wins, 2);
        chk("mix_dw", dealer_wins, 2);
        chk("mix_ties", ties, 1);
        chk("mix_round", round_num, 5);
        chk("mix_winner", match_winner, 2'b11);

        // Timeout on the 15th DEAL edge, after one real round.
        start_new();
        do_round(2'b01, 2, ended);
        advance();
        {dealer_win_light, player_win_light} = 2'b00;
        tick();
        repeat (14) tick();
        chk("tmo_not_yet", error, 0);
        chk("tmo_still_busy", busy, 1);
        m_err = 1'b1;
        push_exp(1'b0, 1'b0);
        tick();
        chk("tmo_err", error, 1);
        chk("tmo_erb", engine_resetb, 0);
        chk("tmo_round", round_num, 1);
        chk("tmo_pw", player_wins, 1);
        next_round = 1'b1;
        tick();
        next_round = 1'b0;
        chk("err_ignores_next", error, 1);
        start_new();

        // Reset during DEAL of round 2, with a light raised at the reset edge.
        do_round(2'b10, 2, ended);
        advance();
        {dealer_win_light, player_win_light} = 2'b00;
        tick();
        tick();
        resetb = 1'b0;
        player_win_light = 1'b1;
        model_clear();
        push_exp(1'b0, 1'b0);
        tick();
        chk("mid_rst_round", round_num, 0);
        chk("mid_rst_dw", dealer_wins, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_erb", engine_resetb, 0);
        resetb = 1'b1;
        player_win_light = 1'b0;
        tick();
        chk("post_rst_idle", busy, 0);

        // Priority and stale lights in HOLD.
        start_new();
        do_round(2'b01, 2, ended);
        repeat (3) tick();
        chk("stale_pw", player_wins, 1);
        chk("stale_round", round_num, 1);
        start_match = 1'b1;
        tick();
        chk("hold_ignores_start", busy, 0);
        chk("hold_keeps_pw", player_wins, 1);
        next_round = 1'b1;
        tick();
        start_match = 1'b0;
        next_round = 1'b0;
        chk("prio_busy", busy, 1);
        chk("prio_erb", engine_resetb, 0);
        chk("prio_round", round_num, 1);
        chk("prio_pw", player_wins, 1);
        do_round(2'b10, 1, ended);
        chk("prio_r2_pw", player_wins, 1);
        chk("prio_r2_dw", dealer_wins, 1);
        chk("prio_r2_round", round_num, 2);

        tick();
        chk("sb_drain", exp_q.size(), 0);
        mon_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
